// File: rtl/cordic_host_seq.sv
// cordic_host_seq: host-side sequencer for a CORDIC engine that shares a
// byte-wide dual-port BRAM with this block. One transaction writes the six
// operand words, releases the engine, waits for its completion flag, reclaims
// the memory and reads the six result words back.
//
// Optional feature: define CORDIC_HOST_TIMEOUT_EN to bound the WAIT phase by
// TIMEOUT cycles. A timeout raises err and finishes without reading results.
// Without the macro, WAIT lasts until triggerin and err is tied to 0.
//
// Handshake: start is a single-cycle request that is only accepted in IDLE.
// done is a single-cycle pulse in FINISH. busy is high in every non-IDLE state.
// triggerin is sampled only in WAIT. The memory has a 1-cycle read latency:
// an address issued in cycle k returns data on memdout in cycle k+1.
//
// dbg_state exposes the FSM state encoding for observation.
module cordic_host_seq #(
  parameter logic [15:0] OP_BASE  = 16'd0,
  parameter logic [15:0] RES_BASE = 16'd11,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] rot_x_in,
  input  logic [15:0] rot_y_in,
  input  logic [15:0] rot_z_in,
  input  logic [15:0] vec_x_in,
  input  logic [15:0] vec_y_in,
  input  logic [15:0] vec_z_in,
  output logic [15:0] memaddr,
  output logic [7:0]  memdin,
  output logic        memwen,
  input  logic [7:0]  memdout,
  output logic        memctl,
  input  logic        triggerin,
  output logic [15:0] rot_x,
  output logic [15:0] rot_y,
  output logic [15:0] rot_z,
  output logic [15:0] vec_x,
  output logic [15:0] vec_y,
  output logic [15:0] vec_z,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RELEASE = 3'd2,
    S_WAIT    = 3'd3,
    S_RECLAIM = 3'd4,
    S_READ    = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t      r_state;
  logic [3:0]  r_k;        // byte index in WRITE, issue/capture index in READ
  logic [95:0] r_ops;      // operand bytes, byte 0 = rot_x low byte
  logic [87:0] r_buf;      // result bytes 0..10; byte 11 is merged on commit
  logic [95:0] r_res;      // committed results, same byte layout as r_ops
  logic [15:0] r_memaddr;
  logic [7:0]  r_memdin;
  logic        r_memwen;
  logic        r_memctl;
  logic        r_busy;
  logic        r_done;

  logic [3:0]  w_k_inc;
  logic [3:0]  w_k_dec;
  logic [7:0]  w_op_byte;

  assign w_k_inc   = r_k + 4'd1;
  assign w_k_dec   = r_k - 4'd1;
  // Next operand byte to write; only consumed while r_k < 11.
  assign w_op_byte = r_ops[{w_k_inc, 3'b000} +: 8];

`ifdef CORDIC_HOST_TIMEOUT_EN
  logic [15:0] r_wcnt;
  logic [15:0] w_wcnt_inc;
  logic        r_err;
  assign w_wcnt_inc = r_wcnt + 16'd1;
  assign err        = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign err              = 1'b0;
`endif

  // Transaction sequencer: state, memory port, status and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= 4'd0;
      r_ops     <= '0;
      r_buf     <= '0;
      r_res     <= '0;
      r_memaddr <= 16'd0;
      r_memdin  <= 8'd0;
      r_memwen  <= 1'b0;
      r_memctl  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef CORDIC_HOST_TIMEOUT_EN
      r_wcnt    <= 16'd0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ops     <= {vec_z_in, vec_y_in, vec_x_in, rot_z_in, rot_y_in, rot_x_in};
            r_k       <= 4'd0;
            r_memwen  <= 1'b1;
            r_memaddr <= OP_BASE;
            r_memdin  <= rot_x_in[7:0];
            r_busy    <= 1'b1;
            r_state   <= S_WRITE;
`ifdef CORDIC_HOST_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          if (r_k == 4'd11) begin
            r_memwen <= 1'b0;
            r_memctl <= 1'b0;
            r_state  <= S_RELEASE;
          end else begin
            r_k       <= w_k_inc;
            r_memaddr <= OP_BASE + {12'd0, w_k_inc};
            r_memdin  <= w_op_byte;
          end
        end
        S_RELEASE: begin
          r_state <= S_WAIT;
`ifdef CORDIC_HOST_TIMEOUT_EN
          r_wcnt  <= 16'd0;
`endif
        end
        S_WAIT: begin
          if (triggerin) begin
            r_memctl  <= 1'b1;
            r_memaddr <= RES_BASE;
            r_state   <= S_RECLAIM;
          end
`ifdef CORDIC_HOST_TIMEOUT_EN
          else if (w_wcnt_inc == TIMEOUT) begin
            r_err     <= 1'b1;
            r_memctl  <= 1'b1;
            r_memaddr <= RES_BASE;
            r_state   <= S_RECLAIM;
          end else begin
            r_wcnt <= w_wcnt_inc;
          end
`endif
        end
        S_RECLAIM: begin
`ifdef CORDIC_HOST_TIMEOUT_EN
          if (r_err) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else
`endif
          begin
            r_k     <= 4'd0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // memdout now holds the byte addressed in the previous cycle.
          if (r_k != 4'd0 && r_k != 4'd12) begin
            r_buf[{w_k_dec, 3'b000} +: 8] <= memdout;
          end
          if (r_k < 4'd11) begin
            r_memaddr <= RES_BASE + {12'd0, w_k_inc};
          end
          if (r_k == 4'd12) begin
            r_res   <= {memdout, r_buf};
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_k <= w_k_inc;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign memaddr   = r_memaddr;
  assign memdin    = r_memdin;
  assign memwen    = r_memwen;
  assign memctl    = r_memctl;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

  assign rot_x = r_res[15:0];
  assign rot_y = r_res[31:16];
  assign rot_z = r_res[47:32];
  assign vec_x = r_res[63:48];
  assign vec_y = r_res[79:64];
  assign vec_z = r_res[95:80];

endmodule

// File: tb/tb_cordic_host_seq.sv
// tb_cordic_host_seq: directed bench for cordic_host_seq with a behavioural
// BRAM and CORDIC engine. A second instance with OP_BASE=16'hFFFA shares the
// start/reset stimulus to observe address wrap-around on its write port.
module tb_cordic_host_seq;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] rot_x_in, rot_y_in, rot_z_in, vec_x_in, vec_y_in, vec_z_in;
  logic [15:0] memaddr;
  logic [7:0]  memdin;
  logic        memwen;
  logic [7:0]  memdout;
  logic        memctl;
  logic        triggerin;
  logic [15:0] rot_x, rot_y, rot_z, vec_x, vec_y, vec_z;
  logic        busy, done, err;
  logic [2:0]  dbg_state;

  // Wrap instance signals
  logic [15:0] w_memaddr;
  logic [7:0]  w_memdin;
  logic        w_memwen;
  logic        w_memctl;
  logic [15:0] w_rot_x, w_rot_y, w_rot_z, w_vec_x, w_vec_y, w_vec_z;
  logic        w_busy, w_done, w_err;
  logic [2:0]  w_dbg_state;

  cordic_host_seq #(.OP_BASE(16'd0), .RES_BASE(16'd11), .TIMEOUT(16'd8)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .rot_x_in(rot_x_in), .rot_y_in(rot_y_in), .rot_z_in(rot_z_in),
    .vec_x_in(vec_x_in), .vec_y_in(vec_y_in), .vec_z_in(vec_z_in),
    .memaddr(memaddr), .memdin(memdin), .memwen(memwen), .memdout(memdout),
    .memctl(memctl), .triggerin(triggerin),
    .rot_x(rot_x), .rot_y(rot_y), .rot_z(rot_z),
    .vec_x(vec_x), .vec_y(vec_y), .vec_z(vec_z),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  cordic_host_seq #(.OP_BASE(16'hFFFA)) u_wrap (
    .clk(clk), .rst(rst), .start(start),
    .rot_x_in(rot_x_in), .rot_y_in(rot_y_in), .rot_z_in(rot_z_in),
    .vec_x_in(vec_x_in), .vec_y_in(vec_y_in), .vec_z_in(vec_z_in),
    .memaddr(w_memaddr), .memdin(w_memdin), .memwen(w_memwen), .memdout(8'h00),
    .memctl(w_memctl), .triggerin(1'b0),
    .rot_x(w_rot_x), .rot_y(w_rot_y), .rot_z(w_rot_z),
    .vec_x(w_vec_x), .vec_y(w_vec_y), .vec_z(w_vec_z),
    .busy(w_busy), .done(w_done), .err(w_err), .dbg_state(w_dbg_state)
  );

  // Behavioural BRAM (1-cycle read) and engine: when released, the engine
  // deposits result bytes 8'h01..8'h0C at addresses 11..22 and raises
  // triggerin once memctl has been low for 20 clock edges.
  logic [7:0]  mem [0:65535];
  logic        memctl_q = 1'b1;
  int          eng_cnt = 0;
  logic        eng_en;
  logic        trig_force;

  always @(posedge clk) begin
    if (memwen) mem[memaddr] <= memdin;
    memdout <= mem[memaddr];
    if (memctl_q && !memctl) begin
      for (int i = 0; i < 12; i++) mem[11 + i] <= 8'(i + 1);
    end
    memctl_q <= memctl;
    eng_cnt  <= memctl ? 0 : eng_cnt + 1;
  end

  assign triggerin = trig_force | (eng_en & ~memctl & (eng_cnt >= 20));

  // Write-port and done monitors
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [15:0] wa_addr_q[$];
  logic [7:0]  wa_data_q[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (memwen) begin
      wr_addr_q.push_back(memaddr);
      wr_data_q.push_back(memdin);
    end
    if (w_memwen) begin
      wa_addr_q.push_back(w_memaddr);
      wa_data_q.push_back(w_memdin);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;
  int d0;
  logic [15:0] exp_a;
  logic [7:0]  exp_d;

  initial begin
    rst = 1'b1; start = 1'b0; eng_en = 1'b1; trig_force = 1'b0;
    rot_x_in = '0; rot_y_in = '0; rot_z_in = '0;
    vec_x_in = '0; vec_y_in = '0; vec_z_in = '0;
    repeat (3) step();

    // Reset state
    check("rst_memctl", memctl, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_memwen", memwen, 0);
    check("rst_memaddr", memaddr, 0);
    check("rst_memdin", memdin, 0);
    check("rst_rot_x", rot_x, 0);
    check("rst_vec_z", vec_z, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    step();

    // Transaction 1: full run, W=20, trigger glitch in WRITE, start in WAIT
    rot_x_in = 16'h1234; rot_y_in = 16'h5678; rot_z_in = 16'h9ABC;
    vec_x_in = 16'hDEF0; vec_y_in = 16'h0F1E; vec_z_in = 16'h2D3C;
    wr_addr_q.delete(); wr_data_q.delete();
    wa_addr_q.delete(); wa_data_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    check("t1_wr0_memwen", memwen, 1);
    check("t1_wr0_addr", memaddr, 16'h0000);
    check("t1_wr0_data", memdin, 8'h34);
    check("t1_busy", busy, 1);
    step(); n = 2;
    check("t1_wr1_addr", memaddr, 16'h0001);
    check("t1_wr1_data", memdin, 8'h12);
    while (!done && n < 200) begin
      trig_force = (n == 5);
      start      = (n == 20);
      step(); n++;
      if (n == 13) begin
        check("t1_release_memctl", memctl, 0);
        check("t1_release_memwen", memwen, 0);
      end
    end
    trig_force = 1'b0; start = 1'b0;
    check("t1_latency", n, 48);
    check("t1_done", done, 1);
    check("t1_busy_finish", busy, 1);
    check("t1_rot_x", rot_x, 16'h0201);
    check("t1_rot_y", rot_y, 16'h0403);
    check("t1_rot_z", rot_z, 16'h0605);
    check("t1_vec_x", vec_x, 16'h0807);
    check("t1_vec_y", vec_y, 16'h0A09);
    check("t1_vec_z", vec_z, 16'h0C0B);
    check("t1_err", err, 0);
    step();
    check("t1_done_drop", done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_done_count", done_cnt, 1);
    check("t1_hold_rot_x", rot_x, 16'h0201);

    // Written bytes, low byte first per word
    exp_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A,
              8'hF0, 8'hDE, 8'h1E, 8'h0F, 8'h3C, 8'h2D};
    check("t1_write_count", wr_addr_q.size(), 12);
    check("wrap_write_count", wa_addr_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      exp_d = exp_q.pop_front();
      exp_a = 16'hFFFA + 16'(i);
      if (i < wr_addr_q.size()) begin
        check($sformatf("t1_waddr%0d", i), wr_addr_q[i], 16'(i));
        check($sformatf("t1_wdata%0d", i), wr_data_q[i], exp_d);
      end
      if (i < wa_addr_q.size()) begin
        check($sformatf("wrap_waddr%0d", i), wa_addr_q[i], exp_a);
        check($sformatf("wrap_wdata%0d", i), wa_data_q[i], exp_d);
      end
    end

    // Transaction 2: engine never completes
    eng_en = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
`ifdef CORDIC_HOST_TIMEOUT_EN
    while (!done && n < 200) begin
      step(); n++;
    end
    check("to_latency", n, 23);
    check("to_err", err, 1);
    check("to_memctl", memctl, 1);
    check("to_rot_x", rot_x, 16'h0201);
    check("to_vec_z", vec_z, 16'h0C0B);
    step();
    check("to_idle_busy", busy, 0);
    check("to_err_hold", err, 1);
`else
    repeat (60) step();
    check("nto_busy", busy, 1);
    check("nto_memctl", memctl, 0);
    check("nto_err", err, 0);
    check("nto_done_count", done_cnt, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("nto_rst_busy", busy, 0);
    check("nto_rst_rot_x", rot_x, 0);
`endif

    // Transaction 3: normal run after the stalled one
    eng_en = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    check("t3_err_clear", err, 0);
    check("t3_busy", busy, 1);
    while (!done && n < 200) begin
      step(); n++;
    end
    check("t3_latency", n, 48);
    check("t3_rot_z", rot_z, 16'h0605);
    check("t3_vec_y", vec_y, 16'h0A09);
    step();

    // Transaction 4: reset during READ cycle 5 (cycle 40 of the transaction)
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (n < 40) begin
      step(); n++;
    end
    check("t4_read_memctl", memctl, 1);
    check("t4_read_busy", busy, 1);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_abort_busy", busy, 0);
    check("t4_abort_memctl", memctl, 1);
    check("t4_abort_memwen", memwen, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_rot_x", rot_x, 0);
    check("t4_abort_vec_z", vec_z, 0);
    check("t4_abort_state", dbg_state, 0);
    repeat (40) step();
    check("t4_no_done", done_cnt, d0);
    check("t4_still_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
